// File: rtl/if_stage_pc_unit.sv
// Instruction-fetch stage: PC register, imem address and IF/ID register.
// Applies EX branch / ID jump redirects, load-use stall and imem wait.
//
// Ports:
//   clk, reset (async, active-low)
//   imem_addr/imem_rdata/imem_ready : instruction memory
//   stall                           : freeze PC and IF/ID
//   id_jop/id_pcsrc/id_rs_data      : ID-stage jump controls
//   ex_branch/ex_branch_taken/
//   ex_branch_target                : EX-stage branch resolution
//   pc, if_id_*                     : fetch PC and IF/ID register
//   ex_flush                        : ID/EX loads a bubble this cycle
module if_stage_pc_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   input  logic        stall,
   input  logic        id_jop,
   input  logic [1:0]  id_pcsrc,
   input  logic [31:0] id_rs_data,
   input  logic        ex_branch,
   input  logic        ex_branch_taken,
   input  logic [31:0] ex_branch_target,
   output logic [31:0] pc,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc_plus4,
   output logic        if_id_valid,
   output logic        ex_flush
);

   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_pc4;
   logic        r_valid;

   logic        w_redir_ex;
   logic        w_redir_id;
   logic        w_pcsrc_ok;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_jmp_tgt;
   logic [31:0] w_br_tgt;
   logic [31:0] w_pc_next;
   logic        w_unused;

   assign w_redir_ex = ex_branch & ex_branch_taken;
   assign w_pcsrc_ok = (id_pcsrc == 2'd1) | (id_pcsrc == 2'd2);

   // A jump in ID is dropped while stalled (rs may still be pending)
   // or when an older taken branch in EX makes it wrong-path.
   assign w_redir_id = r_valid & id_jop & w_pcsrc_ok
                     & ~stall & ~w_redir_ex;

   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_br_tgt   = {ex_branch_target[31:2], 2'b00};
   assign w_jmp_tgt  = (id_pcsrc == 2'd1)
                     ? {r_pc4[31:28], r_instr[25:0], 2'b00}
                     : {id_rs_data[31:2], 2'b00};

   assign w_unused = ^{id_rs_data[1:0], ex_branch_target[1:0]};

   always_comb begin
      w_pc_next = w_pc_plus4;
      if (w_redir_ex)
         w_pc_next = w_br_tgt;
      else if (w_redir_id)
         w_pc_next = w_jmp_tgt;
      else if (stall || !imem_ready)
         w_pc_next = r_pc;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_pc <= RESET_PC;
      else
         r_pc <= w_pc_next;
   end

   // Memory wait bubbles the instruction but keeps the old pc_plus4.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_instr <= NOP_INSTR;
         r_pc4   <= 32'd0;
         r_valid <= 1'b0;
      end else if (w_redir_ex || w_redir_id) begin
         r_instr <= NOP_INSTR;
         r_pc4   <= 32'd0;
         r_valid <= 1'b0;
      end else if (stall) begin
         r_instr <= r_instr;
         r_pc4   <= r_pc4;
         r_valid <= r_valid;
      end else if (!imem_ready) begin
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
      end else begin
         r_instr <= imem_rdata;
         r_pc4   <= w_pc_plus4;
         r_valid <= 1'b1;
      end
   end

   assign pc             = r_pc;
   assign imem_addr      = r_pc;
   assign if_id_instr    = r_instr;
   assign if_id_pc_plus4 = r_pc4;
   assign if_id_valid    = r_valid;
   assign ex_flush       = w_redir_ex;

endmodule

// File: tb/tb_if_stage_pc_unit.sv
// Bench for if_stage_pc_unit: directed scenarios with literal checks,
// then randomized traffic against a behavioural fetch model.
module tb_if_stage_pc_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic        stall;
   logic        id_jop;
   logic [1:0]  id_pcsrc;
   logic [31:0] id_rs_data;
   logic        ex_branch;
   logic        ex_branch_taken;
   logic [31:0] ex_branch_target;
   logic [31:0] pc;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc_plus4;
   logic        if_id_valid;
   logic        ex_flush;

   int vectors = 0;
   int errors  = 0;

   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_pc4;
   logic        m_valid;

   if_stage_pc_unit dut (
      .clk(clk), .reset(reset),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .imem_ready(imem_ready), .stall(stall),
      .id_jop(id_jop), .id_pcsrc(id_pcsrc),
      .id_rs_data(id_rs_data), .ex_branch(ex_branch),
      .ex_branch_taken(ex_branch_taken),
      .ex_branch_target(ex_branch_target),
      .pc(pc), .if_id_instr(if_id_instr),
      .if_id_pc_plus4(if_id_pc_plus4),
      .if_id_valid(if_id_valid), .ex_flush(ex_flush)
   );

   always #5 clk = ~clk;

   task automatic cmp(string name, logic [31:0] act,
                      logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc    = 32'h0;
      m_instr = 32'h0;
      m_pc4   = 32'h0;
      m_valid = 1'b0;
   endtask

   // One clock: check outputs at the falling edge, work out what the
   // fetch stage must hold after the rising edge, then advance.
   task automatic tick();
      logic [31:0] n_pc, n_instr, n_pc4;
      logic        n_valid, br, jmp;
      @(negedge clk);
      br  = ex_branch && ex_branch_taken;
      jmp = m_valid && id_jop && !stall && !br
            && (id_pcsrc == 2'd1 || id_pcsrc == 2'd2);
      cmp("pc", pc, m_pc);
      cmp("imem_addr", imem_addr, m_pc);
      cmp("if_id_instr", if_id_instr, m_instr);
      cmp("if_id_pc_plus4", if_id_pc_plus4, m_pc4);
      cmp("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
      cmp("ex_flush", {31'd0, ex_flush}, {31'd0, br});
      n_pc = m_pc; n_instr = m_instr;
      n_pc4 = m_pc4; n_valid = m_valid;
      if (br || jmp) begin
         if (br)
            n_pc = ex_branch_target & ~32'h3;
         else if (id_pcsrc == 2'd1)
            n_pc = (m_pc4 & 32'hF000_0000)
                 | ((m_instr & 32'h03FF_FFFF) << 2);
         else
            n_pc = id_rs_data & ~32'h3;
         n_instr = 32'h0; n_pc4 = 32'h0; n_valid = 1'b0;
      end else if (stall) begin
         // everything frozen
      end else if (!imem_ready) begin
         n_instr = 32'h0; n_valid = 1'b0;
      end else begin
         n_pc = m_pc + 32'd4;
         n_instr = imem_rdata; n_pc4 = n_pc; n_valid = 1'b1;
      end
      @(posedge clk);
      if (!reset) model_reset();
      else begin
         m_pc = n_pc; m_instr = n_instr;
         m_pc4 = n_pc4; m_valid = n_valid;
      end
      #1;
   endtask

   initial begin
      imem_rdata = 32'h1111_0000; imem_ready = 1'b1;
      stall = 1'b0; id_jop = 1'b0; id_pcsrc = 2'd0;
      id_rs_data = 32'h0; ex_branch = 1'b0;
      ex_branch_taken = 1'b0; ex_branch_target = 32'h0;
      reset = 1'b1;
      model_reset();
      #1 reset = 1'b0;

      // 1. reset for three cycles, then free run
      repeat (3) tick();
      cmp("rst_pc", pc, 32'h0);
      cmp("rst_valid", {31'd0, if_id_valid}, 32'd0);
      reset = 1'b1;
      imem_rdata = 32'h2222_0000;
      tick();
      cmp("run_pc4", pc, 32'h4);
      cmp("run_valid", {31'd0, if_id_valid}, 32'd1);
      cmp("run_ifid_pc4", if_id_pc_plus4, 32'h4);

      // 2. j 0x40 fetched at 4, decoded with pc_plus4=8
      imem_rdata = 32'h0800_0010;
      tick();
      cmp("j_pc8", pc, 32'h8);
      imem_rdata = 32'h3333_0000;
      id_jop = 1'b1; id_pcsrc = 2'd1;
      tick();
      cmp("j_pc", pc, 32'h40);
      cmp("j_bubble", {31'd0, if_id_valid}, 32'd0);
      id_jop = 1'b0; id_pcsrc = 2'd0;
      imem_rdata = 32'h4444_0040;
      tick();
      cmp("j_tgt_pc4", if_id_pc_plus4, 32'h44);
      cmp("j_tgt_instr", if_id_instr, 32'h4444_0040);

      // 3. taken branch beats a jump in ID
      ex_branch = 1'b1; ex_branch_taken = 1'b1;
      ex_branch_target = 32'h100;
      id_jop = 1'b1; id_pcsrc = 2'd1;
      #1 cmp("br_flush", {31'd0, ex_flush}, 32'd1);
      tick();
      cmp("br_pc", pc, 32'h100);
      cmp("br_valid", {31'd0, if_id_valid}, 32'd0);
      ex_branch = 1'b0; ex_branch_taken = 1'b0;
      id_jop = 1'b0; id_pcsrc = 2'd0;
      tick();

      // 4. jr held off by stall
      id_jop = 1'b1; id_pcsrc = 2'd2; id_rs_data = 32'h203;
      stall = 1'b1;
      repeat (2) tick();
      cmp("jr_stall_pc", pc, 32'h104);
      cmp("jr_stall_pc4", if_id_pc_plus4, 32'h104);
      stall = 1'b0;
      tick();
      cmp("jr_pc", pc, 32'h200);
      id_jop = 1'b0;
      tick();

      // 5. memory wait at 0x20
      id_jop = 1'b1; id_rs_data = 32'h20;
      tick();
      id_jop = 1'b0; imem_ready = 1'b0;
      repeat (3) tick();
      cmp("wait_pc", pc, 32'h20);
      cmp("wait_valid", {31'd0, if_id_valid}, 32'd0);
      imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      cmp("wait_instr", if_id_instr, 32'hDEAD_BEEF);
      cmp("wait_pc4", if_id_pc_plus4, 32'h24);
      cmp("wait_pc_after", pc, 32'h24);
      stall = 1'b1; imem_ready = 1'b0;
      tick();
      cmp("stall_beats_wait", {31'd0, if_id_valid}, 32'd1);
      stall = 1'b0; imem_ready = 1'b1;

      // 6. wrap at the top of the address space
      id_jop = 1'b1; id_rs_data = 32'hFFFF_FFFF;
      tick();
      cmp("wrap_top", pc, 32'hFFFF_FFFC);
      id_jop = 1'b0;
      tick();
      cmp("wrap_pc", pc, 32'h0);
      cmp("wrap_pc4", if_id_pc_plus4, 32'h0);

      // asynchronous reset in the middle of a redirect
      ex_branch = 1'b1; ex_branch_taken = 1'b1;
      ex_branch_target = 32'h500;
      reset = 1'b0;
      model_reset();
      #1 cmp("async_rst_pc", pc, 32'h0);
      tick();
      cmp("async_rst_pc_hold", pc, 32'h0);
      ex_branch = 1'b0; ex_branch_taken = 1'b0;
      reset = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            reset = 1'b0;
            model_reset();
         end else
            reset = 1'b1;
         imem_rdata = $urandom;
         imem_ready = ($urandom_range(0, 99) < 80);
         stall = ($urandom_range(0, 99) < 15);
         id_jop = ($urandom_range(0, 99) < 30);
         id_pcsrc = 2'($urandom_range(0, 3));
         id_rs_data = $urandom;
         ex_branch = ($urandom_range(0, 99) < 15);
         ex_branch_taken = ($urandom_range(0, 1) == 1);
         ex_branch_target = $urandom;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule
